// File: rtl/axi_rd_burst_responder.sv
// AXI4 read-only burst responder serving 32-bit FIXED/INCR/WRAP bursts from a
// single-port synchronous memory with one-cycle read latency.
module axi_rd_burst_responder #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            ID_WIDTH   = 2,
   parameter int unsigned            MEM_AW     = 14,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  mem_rd,
   output logic [MEM_AW-1:0]     mem_addr,
   input  logic [31:0]           mem_rdata,
   output logic                  busy
);

   localparam int unsigned WW = ADDR_WIDTH - 2;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic {StIdle, StBurst} state_e;

   state_e              state_q;
   logic                arready_q;
   logic                busy_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [WW-1:0]       widx_q;
   logic [7:0]          len_q;
   logic [1:0]          burst_q;
   logic                bad_q;
   logic [7:0]          iss_cnt_q;
   logic                iss_done_q;

   // Beat whose memory read (or error beat) was issued last cycle.
   logic                ret_v_q;
   logic                ret_err_q;
   logic                ret_last_q;

   // Two-entry output buffer: head drives the R channel, skid holds the second beat.
   logic                rvalid_q;
   logic [31:0]         rdata_q;
   logic [1:0]          rresp_q;
   logic                rlast_q;
   logic                sk_v_q;
   logic [31:0]         sk_data_q;
   logic [1:0]          sk_resp_q;
   logic                sk_last_q;

   logic                ar_fire;
   logic [ADDR_WIDTH-1:0] ar_diff;
   logic [WW-1:0]       ar_widx;
   logic                ar_bad;
   logic                unused_addr_bits;
   logic                pop;
   logic [1:0]          occ;
   logic                slot_ok;
   logic                issue;
   logic                in_win;
   logic                beat_err;
   logic [WW-1:0]       len_ext;
   logic [WW-1:0]       widx_inc;
   logic [WW-1:0]       widx_nxt;
   logic [31:0]         push_data;
   logic [1:0]          push_resp;

   assign ar_fire          = s_axi_arvalid & arready_q;
   assign ar_diff          = s_axi_araddr - BASE_ADDR;
   assign ar_widx          = ar_diff[ADDR_WIDTH-1:2];
   assign unused_addr_bits = ^ar_diff[1:0];

   always_comb begin
      ar_bad = 1'b0;
      if (s_axi_arsize != 3'b010) ar_bad = 1'b1;
      if (s_axi_arburst == 2'b11) ar_bad = 1'b1;
      if (s_axi_arburst == BurstWrap &&
          !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_bad = 1'b1;
   end

   // Issue a new beat only while buffered + in-flight beats, net of this cycle's pop, stay below 2.
   assign pop     = rvalid_q & s_axi_rready;
   assign occ     = {1'b0, rvalid_q} + {1'b0, sk_v_q} + {1'b0, ret_v_q};
   assign slot_ok = (occ - {1'b0, pop}) < 2'd2;
   assign issue   = (state_q == StBurst) & ~iss_done_q & slot_ok & ~rst;

   assign in_win   = (widx_q[WW-1:MEM_AW] == '0);
   assign beat_err = bad_q | ~in_win;

   assign mem_rd   = issue & ~beat_err;
   assign mem_addr = widx_q[MEM_AW-1:0];

   assign len_ext  = {{(WW-8){1'b0}}, len_q};
   assign widx_inc = widx_q + WW'(1);

   always_comb begin
      widx_nxt = widx_q;
      case (burst_q)
         BurstFixed: widx_nxt = widx_q;
         BurstIncr:  widx_nxt = widx_inc;
         BurstWrap:  widx_nxt = (widx_q & ~len_ext) | (widx_inc & len_ext);
         default:    widx_nxt = widx_q;
      endcase
   end

   assign push_data = ret_err_q ? 32'd0 : mem_rdata;
   assign push_resp = ret_err_q ? RespSlverr : RespOkay;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         arready_q  <= 1'b0;
         busy_q     <= 1'b0;
         id_q       <= '0;
         widx_q     <= '0;
         len_q      <= '0;
         burst_q    <= '0;
         bad_q      <= 1'b0;
         iss_cnt_q  <= '0;
         iss_done_q <= 1'b0;
         ret_v_q    <= 1'b0;
         ret_err_q  <= 1'b0;
         ret_last_q <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rlast_q    <= 1'b0;
         sk_v_q     <= 1'b0;
         sk_data_q  <= '0;
         sk_resp_q  <= '0;
         sk_last_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               arready_q <= 1'b1;
               if (ar_fire) begin
                  state_q    <= StBurst;
                  arready_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  id_q       <= s_axi_arid;
                  widx_q     <= ar_widx;
                  len_q      <= s_axi_arlen;
                  burst_q    <= s_axi_arburst;
                  bad_q      <= ar_bad;
                  iss_cnt_q  <= s_axi_arlen;
                  iss_done_q <= 1'b0;
               end
            end
            StBurst: begin
               if (issue) begin
                  widx_q <= widx_nxt;
                  if (iss_cnt_q == 8'd0) iss_done_q <= 1'b1;
                  else                   iss_cnt_q  <= iss_cnt_q - 8'd1;
               end
               if (pop && rlast_q) begin
                  state_q   <= StIdle;
                  arready_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase

         ret_v_q    <= issue;
         ret_err_q  <= beat_err;
         ret_last_q <= issue & (iss_cnt_q == 8'd0);

         if (pop) begin
            if (sk_v_q) begin
               rdata_q <= sk_data_q;
               rresp_q <= sk_resp_q;
               rlast_q <= sk_last_q;
               sk_v_q  <= ret_v_q;
               if (ret_v_q) begin
                  sk_data_q <= push_data;
                  sk_resp_q <= push_resp;
                  sk_last_q <= ret_last_q;
               end
            end else if (ret_v_q) begin
               rdata_q <= push_data;
               rresp_q <= push_resp;
               rlast_q <= ret_last_q;
            end else begin
               rvalid_q <= 1'b0;
            end
         end else if (ret_v_q) begin
            if (!rvalid_q) begin
               rvalid_q <= 1'b1;
               rdata_q  <= push_data;
               rresp_q  <= push_resp;
               rlast_q  <= ret_last_q;
            end else begin
               sk_v_q    <= 1'b1;
               sk_data_q <= push_data;
               sk_resp_q <= push_resp;
               sk_last_q <= ret_last_q;
            end
         end
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rid     = id_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_axi_rd_burst_responder.sv
// Directed bench for axi_rd_burst_responder with a one-cycle-latency memory model
// where mem[i] = 0xA000_0000 + i.
module tb_axi_rd_burst_responder;

   localparam int unsigned      AW   = 32;
   localparam int unsigned      IDW  = 2;
   localparam int unsigned      MAW  = 6;
   localparam logic [31:0]      BASE = 32'h0000_1000;

   logic           clk;
   logic           rst;
   logic           arvalid;
   logic           arready;
   logic [IDW-1:0] arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic           rvalid;
   logic           rready;
   logic [IDW-1:0] rid;
   logic [31:0]    rdata;
   logic [1:0]     rresp;
   logic           rlast;
   logic           mem_rd;
   logic [MAW-1:0] mem_addr;
   logic [31:0]    mem_rdata;
   logic           busy;

   int cmp_cnt = 0;
   int mis_cnt = 0;
   int cyc = 0;
   int rd_count = 0;
   int ahead = 0;
   int max_ahead = 0;
   logic mon_clr = 1'b0;

   logic [31:0]    bd  [0:31];
   logic [1:0]     br  [0:31];
   logic           bl  [0:31];
   logic [IDW-1:0] bid [0:31];
   int             bc  [0:31];
   int             got;
   int             stall_viol;

   axi_rd_burst_responder #(
      .ADDR_WIDTH (AW),
      .ID_WIDTH   (IDW),
      .MEM_AW     (MAW),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_arid    (arid),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_arsize  (arsize),
      .s_axi_arburst (arburst),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_axi_rid     (rid),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rlast   (rlast),
      .mem_rd        (mem_rd),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: data valid one cycle after mem_rd, garbage otherwise.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= 32'hA000_0000 + 32'(mem_addr);
      else        mem_rdata <= 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      int a;
      cyc <= cyc + 1;
      rd_count <= rd_count + (mem_rd ? 1 : 0);
      if (rst || mon_clr) begin
         ahead     <= 0;
         max_ahead <= 0;
      end else begin
         a = ahead + (mem_rd ? 1 : 0) - ((rvalid && rready) ? 1 : 0);
         ahead <= a;
         if (a > max_ahead) max_ahead <= a;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got %0d required completion", 0);
      $fatal(1, "watchdog");
   end

   task automatic do_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output int t);
      arvalid = 1'b1;
      arid    = id;
      araddr  = addr;
      arlen   = len;
      arsize  = size;
      arburst = burst;
      t = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (arready) begin
            t = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
      arvalid = 1'b0;
   endtask

   // Records accepted beats; counts any R-channel change while stalled.
   task automatic collect(input int n, input bit rnd);
      logic           pstall;
      logic [31:0]    pd;
      logic [1:0]     pr;
      logic           pl;
      logic [IDW-1:0] pid;
      int             budget;
      got = 0;
      stall_viol = 0;
      pstall = 1'b0;
      budget = 0;
      pd = '0; pr = '0; pl = 1'b0; pid = '0;
      while (got < n && budget < 300) begin
         @(negedge clk);
         if (pstall && ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, pd, pr, pl, pid}))
            stall_viol++;
         pstall = rvalid && !rready;
         pd = rdata; pr = rresp; pl = rlast; pid = rid;
         if (rvalid && rready) begin
            bd[got]  = rdata;
            br[got]  = rresp;
            bl[got]  = rlast;
            bid[got] = rid;
            bc[got]  = cyc;
            got++;
         end
         @(posedge clk);
         #1;
         rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         budget++;
      end
      rready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp_cnt++;
      if ({arready, rvalid, rdata, rresp, rlast, rid, mem_rd, mem_addr, busy} !== '0) begin
         mis_cnt++;
         $display("FAIL reset_outputs: got ar=%b rv=%b rd=%h rr=%b rl=%b id=%h mrd=%b ma=%h busy=%b, required all 0",
                  arready, rvalid, rdata, rresp, rlast, rid, mem_rd, mem_addr, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      cmp_cnt++;
      if (arready !== 1'b0) begin
         mis_cnt++;
         $display("FAIL arready_release0: got %b required 0", arready);
      end
      @(negedge clk);
      cmp_cnt++;
      if (arready !== 1'b1 || busy !== 1'b0) begin
         mis_cnt++;
         $display("FAIL arready_release1: got ar=%b busy=%b required ar=1 busy=0", arready, busy);
      end
   endtask

   task automatic test_incr;
      int t;
      do_ar(2'd2, BASE + 32'h10, 8'd3, 3'b010, 2'b01, t);
      cmp_cnt++;
      if (t < 0) begin
         mis_cnt++;
         $display("FAIL incr_ar_timeout: got no handshake required handshake");
      end
      @(negedge clk);
      cmp_cnt++;
      if (mem_rd !== 1'b1 || mem_addr !== 6'd4 || arready !== 1'b0 || busy !== 1'b1) begin
         mis_cnt++;
         $display("FAIL incr_first_rd: got mrd=%b ma=%0d ar=%b busy=%b required 1/4/0/1",
                  mem_rd, mem_addr, arready, busy);
      end
      collect(4, 1'b0);
      cmp_cnt++;
      if (got !== 4) begin
         mis_cnt++;
         $display("FAIL incr_count: got %0d beats required 4", got);
      end
      for (int i = 0; i < 4; i++) begin
         cmp_cnt++;
         if (bd[i] !== 32'hA000_0004 + 32'(i) || br[i] !== 2'b00 || bid[i] !== 2'd2 ||
             bl[i] !== (i == 3) || bc[i] !== t + 3 + i) begin
            mis_cnt++;
            $display("FAIL incr_beat%0d: got d=%h r=%b id=%0d l=%b c=%0d required d=%h r=00 id=2 l=%b c=%0d",
                     i, bd[i], br[i], bid[i], bl[i], bc[i], 32'hA000_0004 + 32'(i), (i == 3), t + 3 + i);
         end
      end
      @(negedge clk);
      cmp_cnt++;
      if (arready !== 1'b1 || busy !== 1'b0) begin
         mis_cnt++;
         $display("FAIL incr_done: got ar=%b busy=%b required ar=1 busy=0", arready, busy);
      end
   endtask

   task automatic test_wrap;
      int t;
      logic [31:0] exp_d [0:3];
      exp_d[0] = 32'hA000_0006; exp_d[1] = 32'hA000_0007;
      exp_d[2] = 32'hA000_0004; exp_d[3] = 32'hA000_0005;
      do_ar(2'd1, BASE + 32'h18, 8'd3, 3'b010, 2'b10, t);
      collect(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cmp_cnt++;
         if (i >= got || bd[i] !== exp_d[i] || br[i] !== 2'b00 || bl[i] !== (i == 3)) begin
            mis_cnt++;
            $display("FAIL wrap_beat%0d: got d=%h r=%b l=%b required d=%h r=00 l=%b",
                     i, bd[i], br[i], bl[i], exp_d[i], (i == 3));
         end
      end
   endtask

   task automatic test_wrap_bad;
      int t;
      int rc0;
      rc0 = rd_count;
      do_ar(2'd0, BASE + 32'h18, 8'd2, 3'b010, 2'b10, t);
      collect(3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cmp_cnt++;
         if (i >= got || bd[i] !== 32'd0 || br[i] !== 2'b10 || bl[i] !== (i == 2)) begin
            mis_cnt++;
            $display("FAIL wrap_bad_beat%0d: got d=%h r=%b l=%b required d=0 r=10 l=%b",
                     i, bd[i], br[i], bl[i], (i == 2));
         end
      end
      cmp_cnt++;
      if (rd_count - rc0 !== 0) begin
         mis_cnt++;
         $display("FAIL wrap_bad_no_rd: got %0d reads required 0", rd_count - rc0);
      end
   endtask

   task automatic test_incr_edge;
      int t;
      int rc0;
      logic [31:0] exp_d [0:3];
      logic [1:0]  exp_r [0:3];
      exp_d[0] = 32'hA000_003E; exp_d[1] = 32'hA000_003F; exp_d[2] = 32'd0; exp_d[3] = 32'd0;
      exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b10; exp_r[3] = 2'b10;
      rc0 = rd_count;
      do_ar(2'd3, BASE + 32'hF8, 8'd3, 3'b010, 2'b01, t);
      collect(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cmp_cnt++;
         if (i >= got || bd[i] !== exp_d[i] || br[i] !== exp_r[i] || bl[i] !== (i == 3)) begin
            mis_cnt++;
            $display("FAIL edge_beat%0d: got d=%h r=%b l=%b required d=%h r=%b l=%b",
                     i, bd[i], br[i], bl[i], exp_d[i], exp_r[i], (i == 3));
         end
      end
      cmp_cnt++;
      if (rd_count - rc0 !== 2) begin
         mis_cnt++;
         $display("FAIL edge_rd_count: got %0d reads required 2", rd_count - rc0);
      end
   endtask

   task automatic test_bad_size;
      int t;
      int rc0;
      rc0 = rd_count;
      do_ar(2'd1, BASE + 32'h0, 8'd1, 3'b001, 2'b01, t);
      collect(2, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cmp_cnt++;
         if (i >= got || bd[i] !== 32'd0 || br[i] !== 2'b10 || bl[i] !== (i == 1)) begin
            mis_cnt++;
            $display("FAIL size_beat%0d: got d=%h r=%b l=%b required d=0 r=10 l=%b",
                     i, bd[i], br[i], bl[i], (i == 1));
         end
      end
      cmp_cnt++;
      if (rd_count - rc0 !== 0) begin
         mis_cnt++;
         $display("FAIL size_no_rd: got %0d reads required 0", rd_count - rc0);
      end
   endtask

   task automatic test_stall;
      int t;
      mon_clr = 1'b1;
      @(posedge clk);
      #1;
      mon_clr = 1'b0;
      do_ar(2'd1, BASE, 8'd15, 3'b010, 2'b01, t);
      collect(16, 1'b1);
      cmp_cnt++;
      if (got !== 16) begin
         mis_cnt++;
         $display("FAIL stall_count: got %0d beats required 16", got);
      end
      for (int i = 0; i < 16; i++) begin
         cmp_cnt++;
         if (i >= got || bd[i] !== 32'hA000_0000 + 32'(i) || br[i] !== 2'b00 || bl[i] !== (i == 15)) begin
            mis_cnt++;
            $display("FAIL stall_beat%0d: got d=%h r=%b l=%b required d=%h r=00 l=%b",
                     i, bd[i], br[i], bl[i], 32'hA000_0000 + 32'(i), (i == 15));
         end
      end
      cmp_cnt++;
      if (stall_viol !== 0) begin
         mis_cnt++;
         $display("FAIL stall_hold: got %0d changes while stalled required 0", stall_viol);
      end
      cmp_cnt++;
      if (max_ahead > 2) begin
         mis_cnt++;
         $display("FAIL stall_ahead: got %0d reads ahead required <= 2", max_ahead);
      end
   endtask

   task automatic test_fixed;
      int t;
      int rc0;
      rc0 = rd_count;
      do_ar(2'd0, BASE + 32'h8, 8'd2, 3'b010, 2'b00, t);
      collect(3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cmp_cnt++;
         if (i >= got || bd[i] !== 32'hA000_0002 || br[i] !== 2'b00 || bl[i] !== (i == 2)) begin
            mis_cnt++;
            $display("FAIL fixed_beat%0d: got d=%h r=%b l=%b required d=a0000002 r=00 l=%b",
                     i, bd[i], br[i], bl[i], (i == 2));
         end
      end
      cmp_cnt++;
      if (rd_count - rc0 !== 3) begin
         mis_cnt++;
         $display("FAIL fixed_rd_count: got %0d reads required 3", rd_count - rc0);
      end
   endtask

   task automatic test_back_to_back;
      int t;
      int t2;
      int lc;
      do_ar(2'd3, BASE + 32'h40, 8'd15, 3'b010, 2'b01, t);
      collect(16, 1'b0);
      lc = bc[15];
      cmp_cnt++;
      if (got !== 16 || lc !== t + 18 || bd[15] !== 32'hA000_001F || bl[15] !== 1'b1) begin
         mis_cnt++;
         $display("FAIL b2b_last: got n=%0d c=%0d d=%h l=%b required n=16 c=%0d d=a000001f l=1",
                  got, lc, bd[15], bl[15], t + 18);
      end
      do_ar(2'd2, BASE + 32'h4, 8'd0, 3'b010, 2'b01, t2);
      cmp_cnt++;
      if (t2 !== lc + 1) begin
         mis_cnt++;
         $display("FAIL b2b_ar_cycle: got %0d required %0d", t2, lc + 1);
      end
      collect(1, 1'b0);
      cmp_cnt++;
      if (got !== 1 || bd[0] !== 32'hA000_0001 || bl[0] !== 1'b1 || bid[0] !== 2'd2) begin
         mis_cnt++;
         $display("FAIL b2b_single: got d=%h l=%b id=%0d required d=a0000001 l=1 id=2",
                  bd[0], bl[0], bid[0]);
      end
   endtask

   task automatic test_mid_reset;
      int t;
      int extra;
      do_ar(2'd2, BASE, 8'd7, 3'b010, 2'b01, t);
      collect(2, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      cmp_cnt++;
      if ({rvalid, busy, arready, mem_rd, rdata, rlast, rid} !== '0) begin
         mis_cnt++;
         $display("FAIL midrst_outputs: got rv=%b busy=%b ar=%b mrd=%b rd=%h rl=%b id=%0d required all 0",
                  rvalid, busy, arready, mem_rd, rdata, rlast, rid);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rvalid) extra++;
      end
      cmp_cnt++;
      if (extra !== 0 || arready !== 1'b1) begin
         mis_cnt++;
         $display("FAIL midrst_quiet: got %0d beats ar=%b required 0 beats ar=1", extra, arready);
      end
      do_ar(2'd1, BASE + 32'h20, 8'd0, 3'b010, 2'b01, t);
      collect(1, 1'b0);
      cmp_cnt++;
      if (got !== 1 || bd[0] !== 32'hA000_0008 || br[0] !== 2'b00 || bl[0] !== 1'b1 || bid[0] !== 2'd1) begin
         mis_cnt++;
         $display("FAIL midrst_new: got n=%0d d=%h r=%b l=%b id=%0d required n=1 d=a0000008 r=00 l=1 id=1",
                  got, bd[0], br[0], bl[0], bid[0]);
      end
   endtask

   initial begin
      rst     = 1'b1;
      arvalid = 1'b0;
      arid    = '0;
      araddr  = '0;
      arlen   = '0;
      arsize  = 3'b010;
      arburst = 2'b01;
      rready  = 1'b1;
      test_reset;
      test_incr;
      test_wrap;
      test_wrap_bad;
      test_incr_edge;
      test_bad_size;
      test_stall;
      test_fixed;
      test_back_to_back;
      test_mid_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
